stream_upsize: RTL and testbench

- Packs a narrow valid/ready byte stream into wide words of RATIO lanes.
- Sits directly upstream of the team's synchronous FIFO:
  - m_valid_o drives FIFO push.
  - m_ready_i is driven by the inverted FIFO full flag.
- Packet boundaries (s_last_i) flush partial words, with a lane keep mask and m_last_o.

---
 rtl/stream_upsize.sv | 73 +++++++
 tb/tb_stream_upsize.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsize.sv
// Packs IN_W-bit beats into RATIO-lane words with a keep mask; s_last flushes a partial word.
// One cycle from completing beat to m_valid_o; input stalls only while an unaccepted output is held.
module stream_upsize #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4,
    localparam int CNT_W = $clog2(RATIO)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [IN_W-1:0]         s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [IN_W*RATIO-1:0]   m_data_o,
    output logic [RATIO-1:0]        m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

    logic [(RATIO-1)*IN_W-1:0] acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      accept;
    logic                      complete;
    logic [IN_W*RATIO-1:0]     word_d;
    logic [RATIO-1:0]          keep_d;

    // Output register may be refilled on the same edge it drains, so no bubble between words.
    assign s_ready_o = !m_valid_o || m_ready_i;
    assign accept    = s_valid_i && s_ready_o;
    assign complete  = accept && (s_last_i || cnt_q == CNT_MAX);

    always_comb begin
        word_d = '0;
        keep_d = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
            if (k < int'(cnt_q)) begin
                word_d[k*IN_W +: IN_W] = acc_q[k*IN_W +: IN_W];
            end
        end
        word_d[int'(cnt_q)*IN_W +: IN_W] = s_data_i;
        for (int k = 0; k < RATIO; k++) begin
            keep_d[k] = (k <= int'(cnt_q));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            m_data_o  <= '0;
            m_keep_o  <= '0;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b0;
        end else if (complete) begin
            m_data_o  <= word_d;
            m_keep_o  <= keep_d;
            m_last_o  <= s_last_i;
            m_valid_o <= 1'b1;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                acc_q[int'(cnt_q)*IN_W +: IN_W] <= s_data_i;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (m_valid_o && m_ready_i) begin
                m_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_upsize.sv
// Directed bench for stream_upsize (IN_W=8, RATIO=4) with a queue-based 8-deep FIFO downstream.
module tb_stream_upsize;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_valid;
    logic        s_ready_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_keep_o;
    logic        m_last_o;
    logic        m_valid_o;
    logic        m_ready;

    logic        tb_ready;
    logic        use_fifo;
    logic        pop_req;
    int          fifo_cnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        int          c;
    } beat_t;
    beat_t outq[$];

    assign m_ready = use_fifo ? (fifo_cnt < 8) : tb_ready;

    stream_upsize #(.IN_W(8), .RATIO(4)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_keep_o  (m_keep_o),
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready)
    );

    always #5 clk_i = ~clk_i;

    // Downstream sink: records every accepted output word; in FIFO mode also tracks occupancy.
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (!rst_i && m_valid_o && m_ready) begin
            outq.push_back('{d: m_data_o, k: m_keep_o, l: m_last_o, c: cyc});
        end
        if (!use_fifo) fifo_cnt <= 0;
        else fifo_cnt <= fifo_cnt + ((!rst_i && m_valid_o && m_ready) ? 1 : 0) - (pop_req ? 1 : 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        s_data = d;
        s_last = l;
        s_valid = 1'b1;
        while (!s_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout word=%h s_ready_o=%b required=1", d, s_ready_o);
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_i = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        tb_ready = 1'b0; use_fifo = 1'b0; pop_req = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", m_valid_o); end
        checks++; if (m_data_o !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=00000000", m_data_o); end
        checks++; if (m_keep_o !== 4'h0) begin failures++; $display("FAIL rst_keep got=%b exp=0000", m_keep_o); end
        checks++; if (m_last_o !== 1'b0) begin failures++; $display("FAIL rst_last got=%b exp=0", m_last_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", s_ready_o); end
        tb_ready = 1'b1;
    endtask

    task automatic test_full_word;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL full_early_valid got=%b exp=0", m_valid_o); end
        send(8'h44, 1'b1);
        s_valid = 1'b0;
        checks++; if (m_valid_o !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", m_valid_o); end
        checks++; if (m_data_o !== 32'h44332211) begin failures++; $display("FAIL full_data got=%h exp=44332211", m_data_o); end
        checks++; if (m_keep_o !== 4'b1111) begin failures++; $display("FAIL full_keep got=%b exp=1111", m_keep_o); end
        checks++; if (m_last_o !== 1'b1) begin failures++; $display("FAIL full_last got=%b exp=1", m_last_o); end
        @(negedge clk_i);
        checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL full_one_cycle got=%b exp=0", m_valid_o); end
    endtask

    task automatic test_partial;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        s_valid = 1'b0;
        checks++; if (m_data_o !== 32'h0000BBAA) begin failures++; $display("FAIL part2_data got=%h exp=0000bbaa", m_data_o); end
        checks++; if (m_keep_o !== 4'b0011) begin failures++; $display("FAIL part2_keep got=%b exp=0011", m_keep_o); end
        checks++; if (m_last_o !== 1'b1) begin failures++; $display("FAIL part2_last got=%b exp=1", m_last_o); end
        send(8'hCC, 1'b1);
        s_valid = 1'b0;
        checks++; if (m_data_o !== 32'h000000CC) begin failures++; $display("FAIL part1_data got=%h exp=000000cc", m_data_o); end
        checks++; if (m_keep_o !== 4'b0001) begin failures++; $display("FAIL part1_keep got=%b exp=0001", m_keep_o); end
        checks++; if (m_valid_o !== 1'b1) begin failures++; $display("FAIL part1_valid got=%b exp=1", m_valid_o); end
        idle(2);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_w [3];
        int not_rdy = 0;
        exp_w = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        outq.delete();
        for (int i = 1; i <= 12; i++) begin
            if (s_ready_o !== 1'b1) not_rdy++;
            send(8'(i), i == 12);
        end
        idle(3);
        checks++; if (not_rdy != 0) begin failures++; $display("FAIL b2b_ready stalls=%0d exp=0", not_rdy); end
        checks++; if (outq.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", outq.size()); end
        if (outq.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (outq[j].d !== exp_w[j] || outq[j].k !== 4'hF || outq[j].l !== (j == 2)) begin
                    failures++;
                    $display("FAIL b2b_word%0d got=%h/%b/%b exp=%h/1111/%b", j, outq[j].d, outq[j].k, outq[j].l, exp_w[j], j == 2);
                end
            end
            checks++;
            if (outq[1].c - outq[0].c != 4 || outq[2].c - outq[1].c != 4) begin
                failures++;
                $display("FAIL b2b_spacing got=%0d,%0d exp=4,4", outq[1].c - outq[0].c, outq[2].c - outq[1].c);
            end
        end
    endtask

    task automatic test_backpressure;
        outq.delete();
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
        tb_ready = 1'b0;
        s_data = 8'h05; s_last = 1'b0; s_valid = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready cyc%0d got=%b exp=0", c, s_ready_o); end
            checks++; if (m_data_o !== 32'h04030201 || m_valid_o !== 1'b1) begin
                failures++; $display("FAIL bp_hold cyc%0d got=%h v=%b exp=04030201 v=1", c, m_data_o, m_valid_o);
            end
            @(negedge clk_i);
        end
        tb_ready = 1'b1;
        #1;
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b1);
        idle(3);
        checks++; if (outq.size() != 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", outq.size()); end
        if (outq.size() == 2) begin
            checks++; if (outq[0].d !== 32'h04030201 || outq[0].l !== 1'b0) begin
                failures++; $display("FAIL bp_word0 got=%h/%b exp=04030201/0", outq[0].d, outq[0].l);
            end
            checks++; if (outq[1].d !== 32'h08070605 || outq[1].l !== 1'b1) begin
                failures++; $display("FAIL bp_word1 got=%h/%b exp=08070605/1", outq[1].d, outq[1].l);
            end
        end
    endtask

    task automatic test_mid_reset;
        outq.delete();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        s_valid = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        send(8'h55, 1'b1);
        s_valid = 1'b0;
        checks++; if (m_data_o !== 32'h00000055) begin failures++; $display("FAIL mrst_data got=%h exp=00000055", m_data_o); end
        checks++; if (m_keep_o !== 4'b0001) begin failures++; $display("FAIL mrst_keep got=%b exp=0001", m_keep_o); end
        idle(2);
        checks++; if (outq.size() != 1) begin failures++; $display("FAIL mrst_count got=%0d exp=1", outq.size()); end
    endtask

    task automatic test_fifo_full;
        int idx = 0;
        int stuck = 0;
        logic acc;
        logic [31:0] exp;
        outq.delete();
        use_fifo = 1'b1;
        for (int c = 0; c < 60; c++) begin
            s_data = 8'(idx + 1);
            s_last = (idx % 4 == 3);
            s_valid = (idx < 40);
            #1;
            acc = s_valid && s_ready_o;
            @(negedge clk_i);
            if (acc) idx++;
        end
        checks++; if (idx != 36) begin failures++; $display("FAIL fifo_accepted got=%0d exp=36", idx); end
        checks++; if (outq.size() != 8) begin failures++; $display("FAIL fifo_pushed got=%0d exp=8", outq.size()); end
        checks++; if (m_valid_o !== 1'b1 || m_data_o !== 32'h24232221) begin
            failures++; $display("FAIL fifo_held got=%h v=%b exp=24232221 v=1", m_data_o, m_valid_o);
        end
        for (int j = 0; j < 8 && j < outq.size(); j++) begin
            exp = {8'(4*j + 4), 8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1)};
            checks++;
            if (outq[j].d !== exp || outq[j].k !== 4'hF || outq[j].l !== 1'b1) begin
                failures++;
                $display("FAIL fifo_word%0d got=%h/%b/%b exp=%h/1111/1", j, outq[j].d, outq[j].k, outq[j].l, exp);
            end
        end
        for (int c = 0; c < 5; c++) begin
            if (s_ready_o !== 1'b0) stuck++;
            @(negedge clk_i);
        end
        checks++; if (stuck != 0) begin failures++; $display("FAIL fifo_ready_hold cycles_ready=%0d exp=0", stuck); end
        pop_req = 1'b1;
        @(negedge clk_i);
        pop_req = 1'b0;
        #1;
        checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL fifo_pop_ready got=%b exp=1", s_ready_o); end
        s_valid = 1'b0;
        use_fifo = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_fifo_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
